// File: rtl/axi_lfsr_slave.sv
// AXI4-Lite slave wrapping a 32-bit Galois LFSR with CTRL/SEED/POLY/STATE registers.
// The LFSR state is also exported as a sideband for on-chip consumers.
module axi_lfsr_slave #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] RESET_SEED         = 32'h0000_0001,
    parameter logic [31:0] RESET_POLY         = 32'h8020_0003
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [31:0]                       lfsr_state,
    output logic                              lfsr_step
);

    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] seed_q, seed_d;
    logic [31:0] poly_q, poly_d;
    logic [31:0] state_q, state_d;
    logic        step_q, step_d;

    logic        wr_en, rd_en;
    logic [1:0]  wr_sel, rd_sel;
    logic        load;
    logic [31:0] load_val;
    logic        step_req;
    logic [31:0] step_val;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    // An all-zero state would lock the LFSR forever.
    function automatic logic [31:0] nz(input logic [31:0] v);
        return (v == 32'h0) ? 32'h0000_0001 : v;
    endfunction

    assign wr_sel   = S_AXI_AWADDR[3:2];
    assign rd_sel   = S_AXI_ARADDR[3:2];
    assign wr_en    = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_en    = arready_q && S_AXI_ARVALID;
    assign step_val = (state_q >> 1) ^ (state_q[0] ? poly_q : 32'h0);

    always_comb begin
        awready_d = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
        arready_d = S_AXI_ARVALID && !rvalid_q && !arready_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        ctrl_d    = ctrl_q;
        seed_d    = seed_q;
        poly_d    = poly_q;
        state_d   = state_q;
        step_d    = 1'b0;
        load      = 1'b0;
        load_val  = seed_q;

        if (wr_en) begin
            bvalid_d = 1'b1;
        end else if (S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        if (rd_en) begin
            rvalid_d = 1'b1;
            unique case (rd_sel)
                2'd0: rdata_d = {30'h0, ctrl_q};
                2'd1: rdata_d = seed_q;
                2'd2: rdata_d = poly_q;
                2'd3: rdata_d = state_q;
            endcase
        end else if (S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end

        if (wr_en) begin
            unique case (wr_sel)
                2'd0: begin
                    if (S_AXI_WSTRB[0]) begin
                        ctrl_d   = S_AXI_WDATA[1:0];
                        load     = S_AXI_WDATA[2];
                        load_val = seed_q;
                    end
                end
                2'd1: seed_d = merge(seed_q, S_AXI_WDATA, S_AXI_WSTRB);
                2'd2: poly_d = merge(poly_q, S_AXI_WDATA, S_AXI_WSTRB);
                2'd3: begin
                    load     = 1'b1;
                    load_val = merge(state_q, S_AXI_WDATA, S_AXI_WSTRB);
                end
            endcase
        end

        step_req = ctrl_q[0] || (rd_en && rd_sel == 2'd3 && ctrl_q[1]);

        // A load overrides any step requested in the same cycle.
        if (load) begin
            state_d = nz(load_val);
        end else if (step_req) begin
            state_d = nz(step_val);
            step_d  = 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            ctrl_q    <= 2'b00;
            seed_q    <= RESET_SEED;
            poly_q    <= RESET_POLY;
            state_q   <= RESET_SEED;
            step_q    <= 1'b0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
            seed_q    <= seed_d;
            poly_q    <= poly_d;
            state_q   <= state_d;
            step_q    <= step_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign lfsr_state    = state_q;
    assign lfsr_step     = step_q;

endmodule

// File: tb/tb_axi_lfsr_slave.sv
// Directed bench for axi_lfsr_slave: register map, LFSR stepping, loads,
// back-pressure on B/R channels and asynchronous reset mid-transaction.
module tb_axi_lfsr_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] lfsr_state;
    logic        lfsr_step;

    int errors = 0;
    int checks = 0;
    logic [31:0] stepq[$];
    logic [31:0] rd_val;
    int n;

    always #5 clk = ~clk;

    axi_lfsr_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .lfsr_state(lfsr_state), .lfsr_step(lfsr_step)
    );

    always @(negedge clk) if (rst_n && lfsr_step) stepq.push_back(lfsr_state);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timeout waiting for handshake", tag);
    endtask

    // Callers are aligned 1 time unit after a rising edge.
    task automatic axi_wr(input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        int k;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!awready && k < 20);
        if (!awready) tmo("wr_aw");
        chk("wready_with_awready", {31'h0, wready}, 32'h1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!bvalid && k < 20);
        if (!bvalid) tmo("wr_b");
        else chk("bresp", {30'h0, bresp}, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic axi_rd(input logic [3:0] a, output logic [31:0] d);
        int k;
        araddr = a; arvalid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!arready && k < 20);
        if (!arready) tmo("rd_ar");
        @(posedge clk); #1;
        arvalid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!rvalid && k < 20);
        if (!rvalid) tmo("rd_r");
        else chk("rresp", {30'h0, rresp}, 32'h0);
        d = rdata;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", lfsr_state, 32'h0000_0001);
        chk("rst_step", {31'h0, lfsr_step}, 32'h0);
        chk("rst_awready", {31'h0, awready}, 32'h0);
        chk("rst_bvalid", {31'h0, bvalid}, 32'h0);
        chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        axi_rd(4'h0, rd_val); chk("rd_ctrl", rd_val, 32'h0000_0000);
        axi_rd(4'h4, rd_val); chk("rd_seed", rd_val, 32'h0000_0001);
        axi_rd(4'h8, rd_val); chk("rd_poly", rd_val, 32'h8020_0003);
        axi_rd(4'hC, rd_val); chk("rd_state", rd_val, 32'h0000_0001);

        // RUN is high from the first write's handshake to the second's: 3 steps.
        stepq.delete();
        axi_wr(4'h0, 32'h1, 4'hF);
        axi_wr(4'h0, 32'h0, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        chk("run_steps", stepq.size(), 32'd3);
        if (stepq.size() >= 3) begin
            chk("run_s1", stepq[0], 32'h8020_0003);
            chk("run_s2", stepq[1], 32'hC030_0002);
            chk("run_s3", stepq[2], 32'h6018_0001);
        end
        chk("run_hold", lfsr_state, 32'h6018_0001);
        axi_rd(4'hC, rd_val); chk("run_rd_state", rd_val, 32'h6018_0001);

        axi_wr(4'h4, 32'h0000_00A5, 4'hF);
        axi_wr(4'h0, 32'h0000_0006, 4'hF);
        chk("load_state", lfsr_state, 32'h0000_00A5);
        axi_rd(4'hC, rd_val); chk("sor_rd1", rd_val, 32'h0000_00A5);
        axi_rd(4'hC, rd_val); chk("sor_rd2", rd_val, 32'h8020_0051);
        chk("sor_after", lfsr_state, 32'hC030_002B);
        axi_rd(4'h0, rd_val); chk("ctrl_load_rd0", rd_val, 32'h0000_0002);
        axi_wr(4'h0, 32'h0, 4'hF);

        axi_wr(4'hC, 32'h0, 4'hF);
        axi_rd(4'hC, rd_val); chk("zero_guard", rd_val, 32'h0000_0001);
        axi_wr(4'h4, 32'hFFFF_FFFF, 4'h1);
        axi_rd(4'h4, rd_val); chk("seed_strb", rd_val, 32'h0000_00FF);
        axi_wr(4'hC, 32'h1234_5678, 4'h3);
        axi_rd(4'hC, rd_val); chk("state_strb", rd_val, 32'h0000_5678);

        // B back-pressure with a second AW/W pair waiting.
        bready = 1'b0;
        awaddr = 4'h4; wdata = 32'h1111_1111; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 20);
        if (!awready) tmo("bp_aw");
        @(posedge clk); #1;
        awaddr = 4'h8; wdata = 32'h55AA_55AA;
        n = 0;
        do begin @(negedge clk); n++; end while (!bvalid && n < 20);
        if (!bvalid) tmo("bp_b");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_bvalid_hold", {31'h0, bvalid}, 32'h1);
            chk("bp_no_awready", {31'h0, awready}, 32'h0);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_bvalid_drop", {31'h0, bvalid}, 32'h0);
        chk("bp_awready_wait", {31'h0, awready}, 32'h0);
        @(negedge clk);
        chk("bp_awready_2nd", {31'h0, awready}, 32'h1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bvalid && n < 20);
        if (!bvalid) tmo("bp_b2");
        @(posedge clk); #1;
        axi_rd(4'h4, rd_val); chk("bp_seed", rd_val, 32'h1111_1111);
        axi_rd(4'h8, rd_val); chk("bp_poly", rd_val, 32'h55AA_55AA);

        // R back-pressure keeps RDATA stable.
        rready = 1'b0;
        araddr = 4'h8; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 20);
        if (!arready) tmo("rp_ar");
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rp_rvalid_hold", {31'h0, rvalid}, 32'h1);
            chk("rp_rdata_hold", rdata, 32'h55AA_55AA);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rp_rvalid_drop", {31'h0, rvalid}, 32'h0);
        @(posedge clk); #1;

        // Asynchronous reset while a read response is pending and RUN=1.
        axi_wr(4'h0, 32'h1, 4'hF);
        rready = 1'b0;
        araddr = 4'h0; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 20);
        if (!arready) tmo("ar_rst");
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 20);
        if (!rvalid) tmo("r_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("arst_state", lfsr_state, 32'h0000_0001);
        chk("arst_step", {31'h0, lfsr_step}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rready = 1'b1;
        @(posedge clk); #1;
        axi_rd(4'h0, rd_val); chk("arst_ctrl", rd_val, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("arst_no_run", lfsr_state, 32'h0000_0001);
        axi_rd(4'h8, rd_val); chk("arst_poly", rd_val, 32'h8020_0003);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
